// File: rtl/chess_clock_pkg.sv
// chess_clock_pkg: shared state encoding, BCD limits and tick divisor for the chess clock
package chess_clock_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_EXPIRED} state_t;
  localparam logic [3:0] BCD_UNIT_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX = 4'd5;
  localparam logic [15:0] MMSS_MAX = 16'h9959;
  localparam int unsigned SEC_PER_MIN = (int'(BCD_TENS_MAX) + 1) * (int'(BCD_UNIT_MAX) + 1);
  localparam int unsigned SEC_MAX = 100 * SEC_PER_MIN - 1;
  localparam int unsigned TICK_DIV = 50_000_000;
  function automatic logic [3:0] bcd_clamp(input logic [3:0] n);
    return (n > BCD_UNIT_MAX) ? BCD_UNIT_MAX : n;
  endfunction
endpackage

// File: rtl/bcd_mmss_step.sv
// bcd_mmss_step: combinational MM:SS update (+INC_SEC and/or -1) with saturation at 00:00 and 99:59
module bcd_mmss_step
  import chess_clock_pkg::*;
#(
  parameter int unsigned INC_SEC = 3
) (
  input  logic [15:0] mmss_i,
  input  logic        inc_i,
  input  logic        dec_i,
  output logic [15:0] mmss_o,
  output logic        zero_o
);
  logic [13:0] total, up, net;
  logic [6:0] mm, ss;
  // Work in binary seconds; the BCD borrow/carry rules fall out of the re-split by 60 and 10.
  always_comb begin
    total = 14'(mmss_i[15:12]) * 14'd600 + 14'(mmss_i[11:8]) * 14'(SEC_PER_MIN)
          + 14'(mmss_i[7:4]) * 14'd10 + 14'(mmss_i[3:0]);
    up = total + (inc_i ? 14'(INC_SEC) : 14'd0);
    net = (dec_i && up != 14'd0) ? up - 14'd1 : up;
    mm = 7'(net / 14'(SEC_PER_MIN));
    ss = 7'(net % 14'(SEC_PER_MIN));
    mmss_o = (net > 14'(SEC_MAX)) ? MMSS_MAX
           : {4'(mm / 7'd10), 4'(mm % 7'd10), 4'(ss / 7'd10), 4'(ss % 7'd10)};
    zero_o = net == 14'd0;
  end
endmodule

// File: rtl/chess_bcd_countdown.sv
// chess_bcd_countdown: per-player MM:SS BCD countdown with Fischer increment and expiry flag
module chess_bcd_countdown
  import chess_clock_pkg::*;
#(
  parameter logic [7:0]  DEFAULT_MIN = 8'h05,
  parameter int unsigned INC_SEC     = 3
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       CE,
  input  logic       LOAD,
  input  logic [7:0] PRESET_MIN,
  input  logic       RUN,
  input  logic       MOVE_DONE,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       EXPIRED,
  output logic       RUNNING
);
  state_t state_q, state_d;
  logic [15:0] time_q, time_d, step_mmss;
  logic step_zero, inc, dec, expired_q, running_q;
  bcd_mmss_step #(.INC_SEC(INC_SEC)) u_step (
    .mmss_i(time_q),
    .inc_i (inc),
    .dec_i (dec),
    .mmss_o(step_mmss),
    .zero_o(step_zero)
  );
  always_comb begin
    inc = !LOAD && MOVE_DONE && (state_q == ST_RUN || state_q == ST_PAUSE);
    dec = !LOAD && CE && RUN && state_q == ST_RUN;
    state_d = state_q;
    time_d = (inc || dec) ? step_mmss : time_q;
    if (LOAD) begin
      time_d = {bcd_clamp(PRESET_MIN[7:4]), bcd_clamp(PRESET_MIN[3:0]), 8'h00};
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = !RUN ? ST_IDLE : (time_q == 16'h0000) ? ST_EXPIRED : ST_RUN;
        ST_RUN:   state_d = !RUN ? ST_PAUSE : (dec && step_zero) ? ST_EXPIRED : ST_RUN;
        ST_PAUSE: state_d = RUN ? ST_RUN : ST_PAUSE;
        default:  state_d = ST_EXPIRED;
      endcase
    end
  end
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= ST_IDLE;
      time_q <= {bcd_clamp(DEFAULT_MIN[7:4]), bcd_clamp(DEFAULT_MIN[3:0]), 8'h00};
      expired_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q <= time_d;
      expired_q <= state_d == ST_EXPIRED;
      running_q <= state_d == ST_RUN;
    end
  end
  assign {digit3, digit2, digit1, digit0} = time_q;
  assign EXPIRED = expired_q;
  assign RUNNING = running_q;
endmodule

// File: tb/tb_chess_bcd_countdown.sv
// tb_chess_bcd_countdown: directed scoreboard bench for the per-player BCD countdown
module tb_chess_bcd_countdown;
  logic clk = 1'b0, clr_n = 1'b0, ce = 1'b0, load = 1'b0, run = 1'b0, md = 1'b0;
  logic [7:0] preset = 8'h00;
  logic [3:0] d0, d1, d2, d3;
  logic expired, running;
  int tests = 0, fails = 0;
  logic [17:0] sb[$];

  always #5 clk = ~clk;

  chess_bcd_countdown #(.DEFAULT_MIN(8'h05), .INC_SEC(3)) dut (
    .CLK(clk), .CLR_N(clr_n), .CE(ce), .LOAD(load), .PRESET_MIN(preset),
    .RUN(run), .MOVE_DONE(md), .digit0(d0), .digit1(d1), .digit2(d2), .digit3(d3),
    .EXPIRED(expired), .RUNNING(running)
  );

  function automatic logic [17:0] ex(input logic [15:0] t, input logic x, input logic r);
    return {t, x, r};
  endfunction

  task automatic compare(input string tag);
    logic [17:0] e, o;
    e = sb.pop_front();
    o = {d3, d2, d1, d0, expired, running};
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got time=%h exp=%b run=%b, expected time=%h exp=%b run=%b",
             tag, o[17:2], o[1], o[0], e[17:2], e[1], e[0]);
    end
  endtask

  task automatic cyc(input logic c, input logic m, input logic r, input logic l,
                     input logic [7:0] p, input bit chk, input logic [17:0] e, input string tag);
    ce = c; md = m; run = r; load = l; preset = p;
    if (chk) sb.push_back(e);
    @(posedge clk);
    #1;
    if (chk) compare(tag);
  endtask

  task automatic ticks(input int n, input logic r);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, r, 1'b0, 8'h00, 1'b0, 18'h0, "");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    #12;
    sb.push_back(ex(16'h0500, 0, 0));
    compare("reset");
    @(negedge clk) clr_n = 1'b1;
    cyc(0, 0, 1, 0, 8'h00, 1, ex(16'h0500, 0, 1), "start_run");
    ticks(47, 1'b1);
    cyc(1, 0, 1, 0, 8'h00, 1, ex(16'h0412, 0, 1), "to_0412");
    #2 clr_n = 1'b0;
    #1 sb.push_back(ex(16'h0500, 0, 0));
    compare("async_reset");
    ce = 1'b0; run = 1'b0;
    @(negedge clk) clr_n = 1'b1;
    cyc(0, 0, 0, 0, 8'h00, 1, ex(16'h0500, 0, 0), "post_reset_idle");
    cyc(0, 0, 0, 1, 8'h01, 1, ex(16'h0100, 0, 0), "load_01");
    cyc(0, 0, 1, 0, 8'h00, 1, ex(16'h0100, 0, 1), "run_01");
    cyc(1, 0, 1, 0, 8'h00, 1, ex(16'h0059, 0, 1), "borrow_0059");
    ticks(9, 1'b1);
    cyc(1, 0, 1, 0, 8'h00, 1, ex(16'h0049, 0, 1), "ten_ce_0049");
    ticks(46, 1'b1);
    cyc(1, 0, 1, 0, 8'h00, 1, ex(16'h0002, 0, 1), "to_0002");
    cyc(1, 0, 1, 0, 8'h00, 1, ex(16'h0001, 0, 1), "to_0001");
    cyc(1, 0, 1, 0, 8'h00, 1, ex(16'h0000, 1, 0), "expire");
    cyc(1, 1, 1, 0, 8'h00, 1, ex(16'h0000, 1, 0), "expired_hold");
    cyc(0, 0, 0, 1, 8'h03, 1, ex(16'h0300, 0, 0), "load_clears_exp");
    cyc(0, 0, 0, 1, 8'h01, 1, ex(16'h0100, 0, 0), "load_01b");
    cyc(0, 0, 1, 0, 8'h00, 1, ex(16'h0100, 0, 1), "run_01b");
    ticks(1, 1'b1);
    cyc(1, 0, 1, 0, 8'h00, 1, ex(16'h0058, 0, 1), "to_0058");
    cyc(0, 1, 1, 0, 8'h00, 1, ex(16'h0101, 0, 1), "inc_carry");
    cyc(0, 0, 0, 1, 8'h99, 1, ex(16'h9900, 0, 0), "load_99");
    cyc(0, 0, 1, 0, 8'h00, 1, ex(16'h9900, 0, 1), "run_99");
    for (int i = 0; i < 19; i++) cyc(0, 1, 1, 0, 8'h00, 0, 18'h0, "");
    cyc(0, 1, 1, 0, 8'h00, 1, ex(16'h9959, 0, 1), "inc_sat");
    cyc(1, 0, 1, 0, 8'h00, 1, ex(16'h9958, 0, 1), "to_9958");
    cyc(0, 1, 1, 0, 8'h00, 1, ex(16'h9959, 0, 1), "inc_sat_9958");
    cyc(0, 0, 0, 1, 8'h01, 1, ex(16'h0100, 0, 0), "load_01c");
    cyc(0, 0, 1, 0, 8'h00, 1, ex(16'h0100, 0, 1), "run_01c");
    ticks(58, 1'b1);
    cyc(1, 0, 1, 0, 8'h00, 1, ex(16'h0001, 0, 1), "to_0001b");
    cyc(1, 1, 1, 0, 8'h00, 1, ex(16'h0003, 0, 1), "inc_dec_same");
    cyc(0, 0, 0, 1, 8'h03, 1, ex(16'h0300, 0, 0), "load_03");
    cyc(0, 0, 1, 0, 8'h00, 1, ex(16'h0300, 0, 1), "run_03");
    ticks(29, 1'b1);
    cyc(1, 0, 1, 0, 8'h00, 1, ex(16'h0230, 0, 1), "to_0230");
    cyc(0, 0, 0, 0, 8'h00, 1, ex(16'h0230, 0, 0), "pause");
    ticks(4, 1'b0);
    cyc(1, 0, 0, 0, 8'h00, 1, ex(16'h0230, 0, 0), "pause_ignores_ce");
    cyc(0, 0, 1, 0, 8'h00, 1, ex(16'h0230, 0, 1), "resume");
    cyc(1, 0, 1, 0, 8'h00, 1, ex(16'h0229, 0, 1), "resume_dec");
    cyc(1, 0, 0, 0, 8'h00, 1, ex(16'h0229, 0, 0), "pause_with_ce");
    cyc(0, 1, 0, 0, 8'h00, 1, ex(16'h0232, 0, 0), "pause_inc");
    cyc(1, 1, 1, 1, 8'hA7, 1, ex(16'h9700, 0, 0), "load_clamp_a7");
    cyc(1, 1, 0, 0, 8'h00, 1, ex(16'h9700, 0, 0), "idle_ignores");
    cyc(1, 1, 1, 1, 8'h3F, 1, ex(16'h3900, 0, 0), "load_clamp_3f");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
